fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 16, width of all PC/address buses.
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 SHALL have port: clock  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port: next_PC_select  in  1  redirect request from decode.
REQ-006 SHALL have port: target_PC  in  ADDRESS_BITS  redirect address from decode.
REQ-007 SHALL have port: imem_req  out  1  instruction memory request valid.
REQ-008 SHALL have port: imem_addr  out  ADDRESS_BITS  request word address (byte address, bits[1:0]=00).
REQ-009 SHALL have port: imem_ready  in  1  memory accepts request this cycle.
REQ-010 SHALL have port: imem_rvalid  in  1  response valid.
REQ-011 SHALL have port: imem_rdata  in  32  response instruction word.
REQ-012 SHALL have port: PC  out  ADDRESS_BITS  PC of instruction presented to decode.
REQ-013 SHALL have port: instr  out  32  instruction presented to decode.
REQ-014 SHALL have port: if_valid  out  1  PC/instr valid.
REQ-015 SHALL have port: id_ready  in  1  decode consumes when if_valid and id_ready both high.

Function
REQ-016 SHALL hold fetch_pc register; imem_addr = fetch_pc; fetch_pc advances by 4, modulo 2^ADDRESS_BITS, on each accepted request (imem_req and imem_ready).
REQ-017 SHALL allow at most one outstanding request; memory responds in order, one or more cycles after acceptance, never same cycle.
REQ-018 SHALL buffer responses in a 2-entry FIFO of {pc, instr}; head drives PC/instr; if_valid = FIFO non-empty.
REQ-019 SHALL drive imem_req only in state REQ and only when FIFO occupancy plus outstanding count is below 2.
REQ-020 SHALL implement FSM IDLE, REQ, WAIT, DRAIN: IDLE->REQ unconditionally; REQ->WAIT on acceptance; WAIT->REQ on imem_rvalid (data pushed); DRAIN->REQ on imem_rvalid (data discarded).
REQ-021 SHALL, when if_valid=0, drive instr=32'h00000013 (NOP) and PC=fetch_pc.
REQ-022 SHALL treat next_PC_select=1 at a clock edge as redirect: fetch_pc <= {target_PC[AB-1:2],2'b00}, FIFO flushed, priority over all other updates.
REQ-023 SHALL on redirect enter DRAIN if a request is outstanding or accepted that same cycle, else REQ; a response arriving that same cycle is discarded.
REQ-024 SHALL, on redirect coincident with id handshake, complete the handshake (head consumed) and still flush remaining entries.
REQ-025 SHALL permit simultaneous push and pop on a full FIFO only when pop occurs; push to full FIFO without pop cannot occur by REQ-019.
REQ-026 SHALL present a pushed instruction on if_valid no earlier than the cycle after imem_rvalid (registered FIFO).

Reset
REQ-027 SHALL, while reset low, force: state=IDLE, fetch_pc=RESET_PC, FIFO empty, outstanding=0, imem_req=0, if_valid=0, instr=32'h00000013, PC=RESET_PC.
REQ-028 SHALL, on reset asserted mid-transaction, drop the outstanding request; any imem_rvalid during or after reset before a new request is ignored.
REQ-029 SHALL issue the first request (imem_addr=RESET_PC) in the second cycle after reset deassertion.

Configuration
REQ-030 SHALL, with FETCH_STARVE_CNT_EN defined, add port starve_count out 32: increments each cycle id_ready=1 and if_valid=0, saturates at 32'hFFFFFFFF, reset to 0 by reset.
REQ-031 SHALL, without FETCH_STARVE_CNT_EN, omit starve_count port and counter logic; all other behaviour identical.

Verification
REQ-032 SHALL cover: reset release, imem_ready=1, 1-cycle response, id_ready=1 -> addresses 0x0000,0x0004,0x0008 fetched, PC/instr delivered in order.
REQ-033 SHALL cover: id_ready=0 for 10 cycles -> exactly two entries buffered, imem_req=0 thereafter, no instruction lost on release.
REQ-034 SHALL cover: redirect target_PC=0x0102 while request to 0x0010 outstanding -> DRAIN, stale response dropped, next imem_addr=0x0100, first delivered PC=0x0100.
REQ-035 SHALL cover: ADDRESS_BITS=16, fetch_pc=0xFFFC accepted -> next imem_addr=0x0000.
REQ-036 SHALL cover: reset pulled low during WAIT, rvalid arriving after release -> ignored, first request to RESET_PC, if_valid=0 until its response.
REQ-037 SHALL cover: FETCH_STARVE_CNT_EN defined, id_ready=1, 3-cycle memory latency -> starve_count increments during empty cycles only.

Source files
------------

// File: rtl/fetch_if.sv
// Handshake bundle between fetch, instruction memory and decode.
// The master modport is the fetch side; the slave modport is the memory/decode side.
interface fetch_if #(
    parameter int ADDRESS_BITS = 16
);
    logic                    next_PC_select;
    logic [ADDRESS_BITS-1:0] target_PC;
    logic                    imem_req;
    logic [ADDRESS_BITS-1:0] imem_addr;
    logic                    imem_ready;
    logic                    imem_rvalid;
    logic [31:0]             imem_rdata;
    logic [ADDRESS_BITS-1:0] PC;
    logic [31:0]             instr;
    logic                    if_valid;
    logic                    id_ready;

    modport master (
        input  next_PC_select, target_PC, imem_ready, imem_rvalid, imem_rdata, id_ready,
        output imem_req, imem_addr, PC, instr, if_valid
    );

    modport slave (
        output next_PC_select, target_PC, imem_ready, imem_rvalid, imem_rdata, id_ready,
        input  imem_req, imem_addr, PC, instr, if_valid
    );
endinterface

// File: rtl/fetch.sv
// Instruction fetch: one outstanding memory request, 2-entry {pc, instr} buffer to decode.
// Optional FETCH_STARVE_CNT_EN adds a saturating decode-starvation counter port.
module fetch #(
    parameter int                      ADDRESS_BITS = 16,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
    input  logic        clock,
    input  logic        reset,
    fetch_if.master     bus
`ifdef FETCH_STARVE_CNT_EN
    ,
    output logic [31:0] starve_count
`endif
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDRESS_BITS-1:0] r_fetch_pc;
    logic [ADDRESS_BITS-1:0] r_req_pc;
    logic                    r_outstanding;
    logic [ADDRESS_BITS-1:0] r_fifo_pc    [2];
    logic [31:0]             r_fifo_instr [2];
    logic                    r_rd_ptr;
    logic                    r_wr_ptr;
    logic [1:0]              r_count;

    logic                    w_imem_req;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_redirect;
    logic                    w_if_valid;
    logic [1:0]              w_occupancy;
    logic [ADDRESS_BITS-1:0] w_redirect_pc;

    assign w_redirect    = bus.next_PC_select;
    assign w_redirect_pc = bus.target_PC & {{(ADDRESS_BITS-2){1'b1}}, 2'b00};
    assign w_if_valid    = (r_count != 2'd0);
    assign w_occupancy   = r_count + {1'b0, r_outstanding};
    assign w_pop         = w_if_valid && bus.id_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_imem_req  = 1'b0;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                w_imem_req = (w_occupancy < 2'd2);
                w_accept   = w_imem_req && bus.imem_ready;
                if (w_accept) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_push = bus.imem_rvalid && !w_redirect;
                if (bus.imem_rvalid) w_state_nxt = S_REQ;
            end
            S_DRAIN: begin
                if (bus.imem_rvalid) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A response landing on the redirect edge retires the request, so nothing is left to drain.
        if (w_redirect) begin
            if (w_accept || (r_outstanding && !bus.imem_rvalid)) begin
                w_state_nxt = S_DRAIN;
            end else begin
                w_state_nxt = S_REQ;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_outstanding <= 1'b0;
        end else begin
            if (w_accept) begin
                r_outstanding <= 1'b1;
                r_req_pc      <= r_fetch_pc;
            end else if (bus.imem_rvalid) begin
                r_outstanding <= 1'b0;
            end
            if (w_redirect) begin
                r_fetch_pc <= w_redirect_pc;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + ADDRESS_BITS'(4);
            end
        end
    end

    // Redirect flushes everything, including an entry popped on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_fifo_pc[i]    <= '0;
                r_fifo_instr[i] <= '0;
            end
        end else if (w_redirect) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]    <= r_req_pc;
                r_fifo_instr[r_wr_ptr] <= bus.imem_rdata;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign bus.imem_req  = w_imem_req;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.if_valid  = w_if_valid;
    assign bus.PC        = w_if_valid ? r_fifo_pc[r_rd_ptr] : r_fetch_pc;
    assign bus.instr     = w_if_valid ? r_fifo_instr[r_rd_ptr] : NOP;

`ifdef FETCH_STARVE_CNT_EN
    logic [31:0] r_starve_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_starve_count <= '0;
        end else if (bus.id_ready && !w_if_valid && (r_starve_count != '1)) begin
            r_starve_count <= r_starve_count + 32'd1;
        end
    end

    assign starve_count = r_starve_count;
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed cycle-vector bench for fetch: table of {inputs, expected outputs} plus reset and
// starvation-counter sequences (the latter only when FETCH_STARVE_CNT_EN is defined).
module tb_fetch;
    localparam int          AB  = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic        Y   = 1'b1;
    localparam logic        N   = 1'b0;
    localparam logic [31:0] Z   = 32'h0;
    localparam logic [AB-1:0] A0 = 16'h0000;

    localparam logic [31:0] I0   = 32'h1111_0001;
    localparam logic [31:0] I1   = 32'h1111_0002;
    localparam logic [31:0] I2   = 32'h1111_0003;
    localparam logic [31:0] I3   = 32'h1111_0004;
    localparam logic [31:0] I4   = 32'h1111_0005;
    localparam logic [31:0] I5   = 32'h1111_0006;
    localparam logic [31:0] ST   = 32'hDEAD_BEEF;
    localparam logic [31:0] I100 = 32'h2222_0100;
    localparam logic [31:0] I200 = 32'h2222_0200;
    localparam logic [31:0] I204 = 32'h2222_0204;
    localparam logic [31:0] IW   = 32'h3333_FFFC;
    localparam logic [31:0] IR   = 32'h4444_0000;

    typedef struct {
        logic          e_req;
        logic [AB-1:0] e_addr;
        logic          e_valid;
        logic [AB-1:0] e_pc;
        logic [31:0]   e_instr;
        logic          ready;
        logic          rvalid;
        logic [31:0]   rdata;
        logic          idr;
        logic          sel;
        logic [AB-1:0] tgt;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    fetch_if #(.ADDRESS_BITS(AB)) bus ();
`ifdef FETCH_STARVE_CNT_EN
    logic [31:0] starve_count;
`endif

    fetch #(
        .ADDRESS_BITS(AB),
        .RESET_PC    (16'h0000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
`ifdef FETCH_STARVE_CNT_EN
        ,
        .starve_count(starve_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic er, input logic [AB-1:0] ea, input logic ev,
                                input logic [AB-1:0] ep, input logic [31:0] ei,
                                input logic rdy, input logic rv, input logic [31:0] rd,
                                input logic idr, input logic sel, input logic [AB-1:0] tgt);
        vec_t v;
        v.e_req = er;  v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
        v.ready = rdy; v.rvalid = rv; v.rdata = rd;   v.idr = idr; v.sel = sel; v.tgt = tgt;
        return v;
    endfunction

    task automatic check(input string tag, input int idx, input vec_t v);
        n_vec++;
        if (bus.imem_req !== v.e_req || bus.imem_addr !== v.e_addr || bus.if_valid !== v.e_valid ||
            bus.PC !== v.e_pc || bus.instr !== v.e_instr) begin
            n_bad++;
            $display("FAIL %s[%0d]: req %b/%b addr %h/%h valid %b/%b pc %h/%h instr %h/%h (got/want)",
                     tag, idx, bus.imem_req, v.e_req, bus.imem_addr, v.e_addr, bus.if_valid,
                     v.e_valid, bus.PC, v.e_pc, bus.instr, v.e_instr);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.imem_ready     = v.ready;
        bus.imem_rvalid    = v.rvalid;
        bus.imem_rdata     = v.rdata;
        bus.id_ready       = v.idr;
        bus.next_PC_select = v.sel;
        bus.target_PC      = v.tgt;
    endtask

    task automatic step(input string tag, input int idx, input vec_t v);
        @(negedge clock);
        check(tag, idx, v);
        drive(v);
    endtask

`ifdef FETCH_STARVE_CNT_EN
    task automatic check_sc(input int idx, input logic [31:0] exp);
        n_vec++;
        if (starve_count !== exp) begin
            n_bad++;
            $display("FAIL starve[%0d]: starve_count %0d, want %0d", idx, starve_count, exp);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rst_v;
        rst_v = mk(N, A0, N, A0, NOP, N, N, Z, N, N, A0);

        // Basic streaming: 1-cycle memory, decode always ready.
        tbl.push_back(mk(N, 16'h0000, N, 16'h0000, NOP, Y, N, Z,  Y, N, A0));
        tbl.push_back(mk(Y, 16'h0000, N, 16'h0000, NOP, Y, N, Z,  Y, N, A0));
        tbl.push_back(mk(N, 16'h0004, N, 16'h0004, NOP, Y, Y, I0, Y, N, A0));
        tbl.push_back(mk(Y, 16'h0004, Y, 16'h0000, I0,  Y, N, Z,  Y, N, A0));
        tbl.push_back(mk(N, 16'h0008, N, 16'h0008, NOP, Y, Y, I1, Y, N, A0));
        tbl.push_back(mk(Y, 16'h0008, Y, 16'h0004, I1,  Y, N, Z,  Y, N, A0));
        tbl.push_back(mk(N, 16'h000C, N, 16'h000C, NOP, Y, Y, I2, Y, N, A0));
        tbl.push_back(mk(Y, 16'h000C, Y, 16'h0008, I2,  N, N, Z,  Y, N, A0));
        // Decode stalled for 10 cycles: two entries fill, request stops, nothing lost.
        tbl.push_back(mk(Y, 16'h000C, N, 16'h000C, NOP, Y, N, Z,  N, N, A0));
        tbl.push_back(mk(N, 16'h0010, N, 16'h0010, NOP, Y, Y, I3, N, N, A0));
        tbl.push_back(mk(Y, 16'h0010, Y, 16'h000C, I3,  Y, N, Z,  N, N, A0));
        tbl.push_back(mk(N, 16'h0014, Y, 16'h000C, I3,  Y, Y, I4, N, N, A0));
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(N, 16'h0014, Y, 16'h000C, I3, Y, N, Z, N, N, A0));
        tbl.push_back(mk(N, 16'h0014, Y, 16'h000C, I3,  Y, N, Z,  Y, N, A0));
        tbl.push_back(mk(Y, 16'h0014, Y, 16'h0010, I4,  Y, N, Z,  Y, N, A0));
        tbl.push_back(mk(N, 16'h0018, N, 16'h0018, NOP, Y, Y, I5, Y, N, A0));
        tbl.push_back(mk(Y, 16'h0018, Y, 16'h0014, I5,  N, N, Z,  Y, N, A0));
        // Redirect to 0x0010, then redirect to 0x0102 while that request is outstanding.
        tbl.push_back(mk(Y, 16'h0018, N, 16'h0018, NOP, N, N, Z,  Y, Y, 16'h0010));
        tbl.push_back(mk(Y, 16'h0010, N, 16'h0010, NOP, Y, N, Z,  Y, N, A0));
        tbl.push_back(mk(N, 16'h0014, N, 16'h0014, NOP, Y, N, Z,  Y, Y, 16'h0102));
        tbl.push_back(mk(N, 16'h0100, N, 16'h0100, NOP, Y, N, Z,  Y, N, A0));
        tbl.push_back(mk(N, 16'h0100, N, 16'h0100, NOP, Y, Y, ST, Y, N, A0));
        tbl.push_back(mk(Y, 16'h0100, N, 16'h0100, NOP, Y, N, Z,  Y, N, A0));
        tbl.push_back(mk(N, 16'h0104, N, 16'h0104, NOP, Y, Y, I100, Y, N, A0));
        tbl.push_back(mk(Y, 16'h0104, Y, 16'h0100, I100, N, N, Z, Y, N, A0));
        // Redirect coincident with a response: response dropped, no drain needed.
        tbl.push_back(mk(Y, 16'h0104, N, 16'h0104, NOP, Y, N, Z,  Y, N, A0));
        tbl.push_back(mk(N, 16'h0108, N, 16'h0108, NOP, Y, Y, ST, Y, Y, 16'h0200));
        tbl.push_back(mk(Y, 16'h0200, N, 16'h0200, NOP, Y, N, Z,  N, N, A0));
        tbl.push_back(mk(N, 16'h0204, N, 16'h0204, NOP, Y, Y, I200, N, N, A0));
        tbl.push_back(mk(Y, 16'h0204, Y, 16'h0200, I200, Y, N, Z, N, N, A0));
        tbl.push_back(mk(N, 16'h0208, Y, 16'h0200, I200, Y, Y, I204, N, N, A0));
        // Redirect with handshake on a full buffer (unaligned target), then redirect with accept.
        tbl.push_back(mk(N, 16'h0208, Y, 16'h0200, I200, Y, N, Z, Y, Y, 16'h0301));
        tbl.push_back(mk(Y, 16'h0300, N, 16'h0300, NOP, Y, N, Z,  Y, Y, 16'h0400));
        tbl.push_back(mk(N, 16'h0400, N, 16'h0400, NOP, N, Y, ST, Y, N, A0));
        // Address wrap at 0xFFFC.
        tbl.push_back(mk(Y, 16'h0400, N, 16'h0400, NOP, N, N, Z,  Y, Y, 16'hFFFE));
        tbl.push_back(mk(Y, 16'hFFFC, N, 16'hFFFC, NOP, Y, N, Z,  Y, N, A0));
        tbl.push_back(mk(N, 16'h0000, N, 16'h0000, NOP, Y, Y, IW, Y, N, A0));
        tbl.push_back(mk(Y, 16'h0000, Y, 16'hFFFC, IW,  N, N, Z,  Y, N, A0));
        tbl.push_back(mk(Y, 16'h0000, N, 16'h0000, NOP, N, N, Z,  Y, N, A0));

        drive(rst_v);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset", 0, rst_v);
        drive(mk(N, A0, N, A0, NOP, Y, Y, ST, Y, Y, 16'h0040));
        @(negedge clock);
        check("reset", 1, rst_v);
        reset = 1'b1;
        foreach (tbl[i]) begin
            if (i != 0) @(negedge clock);
            check("seq", i, tbl[i]);
            drive(tbl[i]);
        end

        // Reset during WAIT; stale response after release is ignored.
        step("rstwait", 0, mk(Y, 16'h0000, N, 16'h0000, NOP, Y, N, Z, Y, N, A0));
        @(negedge clock);
        check("rstwait", 1, mk(N, 16'h0004, N, 16'h0004, NOP, N, N, Z, Y, N, A0));
        reset = 1'b0;
        drive(mk(N, A0, N, A0, NOP, Y, Y, ST, Y, N, A0));
        #1 check("rstwait", 2, rst_v);
        @(negedge clock);
        check("rstwait", 3, rst_v);
        reset = 1'b1;
        check("rstwait", 4, rst_v);
        step("rstwait", 5, mk(Y, 16'h0000, N, 16'h0000, NOP, Y, N, Z,  Y, N, A0));
        step("rstwait", 6, mk(N, 16'h0004, N, 16'h0004, NOP, N, N, Z,  Y, N, A0));
        step("rstwait", 7, mk(N, 16'h0004, N, 16'h0004, NOP, N, Y, IR, Y, N, A0));
        step("rstwait", 8, mk(Y, 16'h0004, Y, 16'h0000, IR,  N, N, Z,  Y, N, A0));
        step("rstwait", 9, mk(Y, 16'h0004, N, 16'h0004, NOP, N, N, Z,  Y, N, A0));

`ifdef FETCH_STARVE_CNT_EN
        begin
            logic [31:0] sc_exp [8];
            vec_t        sc_in  [8];
            sc_exp = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd5, 32'd6};
            sc_in[0] = mk(N, A0, N, A0, NOP, N, N, Z,  Y, N, A0);
            sc_in[1] = mk(N, A0, N, A0, NOP, Y, N, Z,  Y, N, A0);
            sc_in[2] = mk(N, A0, N, A0, NOP, N, N, Z,  Y, N, A0);
            sc_in[3] = mk(N, A0, N, A0, NOP, N, N, Z,  Y, N, A0);
            sc_in[4] = mk(N, A0, N, A0, NOP, N, Y, I0, Y, N, A0);
            sc_in[5] = mk(N, A0, N, A0, NOP, N, N, Z,  Y, N, A0);
            sc_in[6] = mk(N, A0, N, A0, NOP, N, N, Z,  Y, N, A0);
            sc_in[7] = mk(N, A0, N, A0, NOP, N, N, Z,  Y, N, A0);
            @(negedge clock);
            reset = 1'b0;
            drive(sc_in[0]);
            #1 check_sc(100, 32'd0);
            @(negedge clock);
            check_sc(101, 32'd0);
            reset = 1'b1;
            for (int k = 0; k < 8; k++) begin
                if (k != 0) @(negedge clock);
                check_sc(k, sc_exp[k]);
                drive(sc_in[k]);
            end
        end
`endif

        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
